// File: rtl/pc_interval_profiler.sv
// Multi-channel PC hit-interval profiler: each channel times the cycles between
// consecutive hits on its watch address and logs the intervals into a small ring buffer.
module pc_interval_profiler #(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32,
    parameter bit WRAP   = 1'b1,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int NUM_W = PTR_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        pc,
    input  logic                     pc_valid,
    input  logic [NUM_CH*ADDR_W-1:0] watch_addr,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     clear,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [PTR_W-1:0]         rd_idx,
    input  logic                     rd_req,
    output logic [CNT_W-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [NUM_CH*NUM_W-1:0]  count,
    output logic [NUM_CH-1:0]        full,
    output logic [NUM_CH-1:0]        sat
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH*CNT_W-1:0] rd_mem_flat;
    logic [CH_W-1:0]         rd_ch_reg;
    logic                    rd_zero_reg;
    logic                    rd_valid_reg;
    logic [NUM_W-1:0]        rd_count_sel;
    logic                    rd_beyond;

    assign rd_count_sel = count[rd_ch*NUM_W +: NUM_W];
    assign rd_beyond    = ({1'b0, rd_idx} >= rd_count_sel);

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t           state_reg, state_next;
        logic [CNT_W-1:0] cnt_reg, cnt_next;
        logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
        logic [PTR_W-1:0] old_ptr_reg, old_ptr_next;
        logic [NUM_W-1:0] count_reg, count_next;
        logic             sat_reg, sat_next;
        logic             hit, is_full, wr_en;
        logic [PTR_W-1:0] rd_addr;
        logic [CNT_W-1:0] mem [DEPTH];
        logic [CNT_W-1:0] rd_mem_reg;

        assign hit     = pc_valid & ch_en[gi] & (pc == watch_addr[gi*ADDR_W +: ADDR_W]);
        assign is_full = (count_reg == NUM_W'(DEPTH));
        assign rd_addr = old_ptr_reg + rd_idx;

        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            wr_ptr_next  = wr_ptr_reg;
            old_ptr_next = old_ptr_reg;
            count_next   = count_reg;
            sat_next     = sat_reg;
            wr_en        = 1'b0;
            if (clear) begin
                state_next   = ST_IDLE;
                cnt_next     = '0;
                wr_ptr_next  = '0;
                old_ptr_next = '0;
                count_next   = '0;
                sat_next     = 1'b0;
            end else begin
                unique case (state_reg)
                    ST_IDLE: begin
                        cnt_next = '0;
                        if (ch_en[gi]) state_next = ST_ARM;
                    end
                    ST_ARM: begin
                        if (!ch_en[gi]) begin
                            state_next = ST_IDLE;
                        end else if (hit) begin
                            state_next = ST_RUN;
                            cnt_next   = CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        if (!ch_en[gi]) begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end else if (hit) begin
                            cnt_next = CNT_W'(1);
                            if (!is_full) begin
                                wr_en       = 1'b1;
                                wr_ptr_next = wr_ptr_reg + 1'b1;
                                count_next  = count_reg + 1'b1;
                            end else if (WRAP) begin
                                // full ring: the write slot is the oldest entry, so both pointers move
                                wr_en        = 1'b1;
                                wr_ptr_next  = wr_ptr_reg + 1'b1;
                                old_ptr_next = old_ptr_reg + 1'b1;
                            end
                        end else if (cnt_reg == CNT_MAX) begin
                            sat_next = 1'b1;
                        end else begin
                            cnt_next = cnt_reg + 1'b1;
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_reg   <= ST_IDLE;
                cnt_reg     <= '0;
                wr_ptr_reg  <= '0;
                old_ptr_reg <= '0;
                count_reg   <= '0;
                sat_reg     <= 1'b0;
            end else begin
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                wr_ptr_reg  <= wr_ptr_next;
                old_ptr_reg <= old_ptr_next;
                count_reg   <= count_next;
                sat_reg     <= sat_next;
            end
        end

        // Buffer has no reset; a read of a same-cycle write slot sees the old contents.
        always_ff @(posedge clk) begin
            if (wr_en) mem[wr_ptr_reg] <= cnt_reg;
            if (rd_req && (rd_ch == CH_W'(gi))) rd_mem_reg <= mem[rd_addr];
        end

        assign rd_mem_flat[gi*CNT_W +: CNT_W] = rd_mem_reg;
        assign count[gi*NUM_W +: NUM_W]       = count_reg;
        assign full[gi]                       = is_full;
        assign sat[gi]                        = sat_reg;
    end

    // rd_zero_reg masks unwritten or cleared entries so rd_data never exposes stale RAM.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid_reg <= 1'b0;
            rd_zero_reg  <= 1'b1;
            rd_ch_reg    <= '0;
        end else begin
            rd_valid_reg <= rd_req;
            if (rd_req) begin
                rd_zero_reg <= clear | rd_beyond;
                rd_ch_reg   <= rd_ch;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = rd_zero_reg ? '0 : rd_mem_flat[rd_ch_reg*CNT_W +: CNT_W];

endmodule

// File: tb/tb_pc_interval_profiler.sv
// Bench for pc_interval_profiler: two instances (wrapping 8-bit counters, non-wrapping
// 4-bit counters) share one stimulus; read results are scoreboarded per instance.
module tb_pc_interval_profiler;

    localparam int NUM_CH = 4;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int NW     = 3;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic [ADDR_W-1:0]        pc = '0;
    logic                     pc_valid = 1'b0;
    logic [NUM_CH*ADDR_W-1:0] watch_addr = '0;
    logic [NUM_CH-1:0]        ch_en = '0;
    logic                     clear = 1'b0;
    logic [1:0]               rd_ch = '0;
    logic [1:0]               rd_idx = '0;
    logic                     rd_req = 1'b0;
    logic [7:0]               rd_data_a;
    logic [3:0]               rd_data_b;
    logic                     rd_valid_a, rd_valid_b;
    logic [NUM_CH*NW-1:0]     count_a, count_b;
    logic [NUM_CH-1:0]        full_a, full_b, sat_a, sat_b;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_a_q[$];
    logic [63:0] exp_b_q[$];

    always #5 clk = ~clk;

    pc_interval_profiler #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(8), .ADDR_W(ADDR_W), .WRAP(1'b1)) dut_a (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .watch_addr(watch_addr),
        .ch_en(ch_en), .clear(clear), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_req(rd_req),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .count(count_a), .full(full_a), .sat(sat_a)
    );

    pc_interval_profiler #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .CNT_W(4), .ADDR_W(ADDR_W), .WRAP(1'b0)) dut_b (
        .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .watch_addr(watch_addr),
        .ch_en(ch_en), .clear(clear), .rd_ch(rd_ch), .rd_idx(rd_idx), .rd_req(rd_req),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .count(count_b), .full(full_b), .sat(sat_b)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic hit(input logic [31:0] addr);
        pc = addr;
        pc_valid = 1'b1;
        step(1);
        pc_valid = 1'b0;
    endtask

    // g-1 non-valid cycles showing the address, then a hit: interval of exactly g
    task automatic gap(input logic [31:0] addr, input int g);
        pc = addr;
        pc_valid = 1'b0;
        step(g - 1);
        hit(addr);
    endtask

    task automatic rd(input int ch, input int idx, input logic [63:0] ea, input logic [63:0] eb);
        logic [31:0] c32, i32;
        c32 = ch;
        i32 = idx;
        rd_req = 1'b1;
        rd_ch  = c32[1:0];
        rd_idx = i32[1:0];
        exp_a_q.push_back(ea);
        exp_b_q.push_back(eb);
        step(1);
        rd_req = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
    endtask

    function automatic logic [63:0] cnt_of(input logic [NUM_CH*NW-1:0] v, input int ch);
        return 64'(v[ch*NW +: NW]);
    endfunction

    always @(negedge clk) begin
        if (rd_valid_a) begin
            if (exp_a_q.size() == 0) check("a_unexpected_valid", 64'(rd_valid_a), 64'd0);
            else check("a_rd_data", 64'(rd_data_a), exp_a_q.pop_front());
        end
        if (rd_valid_b) begin
            if (exp_b_q.size() == 0) check("b_unexpected_valid", 64'(rd_valid_b), 64'd0);
            else check("b_rd_data", 64'(rd_data_b), exp_b_q.pop_front());
        end
    end

    initial begin
        logic [31:0] seq [8];
        seq = '{32'h10, 32'h20, 32'h10, 32'h00, 32'h20, 32'h10, 32'h10, 32'h20};

        // reset state
        step(2);
        check("rst_count_a", 64'(count_a), 64'd0);
        check("rst_rd_valid_a", 64'(rd_valid_a), 64'd0);
        check("rst_rd_data_a", 64'(rd_data_a), 64'd0);
        check("rst_full_sat_b", 64'({full_b, sat_b}), 64'd0);
        rst = 1'b1;
        step(1);

        // T1 + saturation on the 4-bit instance
        watch_addr = {32'h30, 32'h10, 32'h20, 32'h10};
        ch_en = 4'b0001;
        step(2);
        hit(32'h10);
        gap(32'h10, 7);
        gap(32'h10, 18);
        check("t1_count_a", cnt_of(count_a, 0), 64'd2);
        check("t1_count_b", cnt_of(count_b, 0), 64'd2);
        check("t1_sat_a", 64'(sat_a), 64'd0);
        check("t1_sat_b", 64'(sat_b), 64'd1);
        rd(0, 0, 7, 7);
        rd(0, 1, 18, 15);
        rd(0, 2, 0, 0);
        step(1);

        // clear resets sat and count
        do_clear();
        check("clr_sat_b", 64'(sat_b), 64'd0);
        check("clr_count_b", cnt_of(count_b, 0), 64'd0);
        check("clr_count_a", cnt_of(count_a, 0), 64'd0);

        // T2/T3: six intervals 1..6 into a depth-4 ring
        ch_en = 4'b0010;
        do_clear();
        step(2);
        hit(32'h20);
        for (int g = 1; g <= 6; g++) gap(32'h20, g);
        check("t2_count_a", cnt_of(count_a, 1), 64'd4);
        check("t3_count_b", cnt_of(count_b, 1), 64'd4);
        check("t2_full_a", 64'(full_a), 64'b0010);
        check("t3_full_b", 64'(full_b), 64'b0010);
        for (int i = 0; i < 4; i++) rd(1, i, 64'(i + 3), 64'(i + 1));
        step(1);

        // disabled channel ignores hits and keeps its log
        ch_en = 4'b0000;
        step(1);
        hit(32'h20);
        hit(32'h20);
        check("dis_count_a", cnt_of(count_a, 1), 64'd4);
        check("dis_full_b", 64'(full_b), 64'b0010);
        rd(1, 0, 3, 1);
        step(1);

        // T5: shared and independent watch addresses
        ch_en = 4'b0111;
        do_clear();
        step(2);
        for (int i = 0; i < 8; i++) begin
            pc = seq[i];
            pc_valid = 1'b1;
            step(1);
        end
        pc_valid = 1'b0;
        check("t5_count_a", 64'(count_a), {52'd0, 3'd0, 3'd3, 3'd2, 3'd3});
        check("t5_count_b", 64'(count_b), {52'd0, 3'd0, 3'd3, 3'd2, 3'd3});
        rd(0, 0, 2, 2);
        rd(0, 1, 3, 3);
        rd(0, 2, 1, 1);
        rd(2, 0, 2, 2);
        rd(2, 1, 3, 3);
        rd(2, 2, 1, 1);
        rd(1, 0, 3, 3);
        rd(1, 1, 3, 3);
        // clear in a hit cycle with a concurrent read
        clear = 1'b1;
        pc = 32'h10;
        pc_valid = 1'b1;
        rd(0, 0, 0, 0);
        clear = 1'b0;
        pc_valid = 1'b0;
        check("t5_clr_count_a", 64'(count_a), 64'd0);
        check("t5_clr_count_b", 64'(count_b), 64'd0);
        step(2);
        hit(32'h10);
        check("t5_rearm_count_a", cnt_of(count_a, 0), 64'd0);
        gap(32'h10, 2);
        check("t5_after_count_a", cnt_of(count_a, 0), 64'd1);
        rd(0, 0, 2, 2);
        step(1);

        // T6: asynchronous reset mid-run
        ch_en = 4'b0001;
        do_clear();
        step(2);
        hit(32'h10);
        gap(32'h10, 20);
        rd(0, 0, 20, 15);
        step(3);
        check("t6_pre_sat_b", 64'(sat_b), 64'd1);
        check("t6_pre_count_a", cnt_of(count_a, 0), 64'd1);
        rst = 1'b0;
        #1;
        check("t6_rst_count_a", 64'(count_a), 64'd0);
        check("t6_rst_sat_b", 64'(sat_b), 64'd0);
        check("t6_rst_rd_data_a", 64'(rd_data_a), 64'd0);
        check("t6_rst_rd_data_b", 64'(rd_data_b), 64'd0);
        check("t6_rst_full_a", 64'(full_a), 64'd0);
        step(2);
        rst = 1'b1;
        step(2);
        hit(32'h10);
        check("t6_first_hit_a", cnt_of(count_a, 0), 64'd0);
        gap(32'h10, 4);
        check("t6_count_a", cnt_of(count_a, 0), 64'd1);
        check("t6_count_b", cnt_of(count_b, 0), 64'd1);
        rd(0, 0, 4, 4);
        rd(0, 1, 0, 0);
        step(3);

        check("sb_drain_a", 64'(exp_a_q.size()), 64'd0);
        check("sb_drain_b", 64'(exp_b_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
